// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join controller: join policies and FSM states.
package fork_join_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'b00,
        JOIN_ANY  = 2'b01,
        JOIN_NONE = 2'b10
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        DRAIN  = 2'b11
    } state_e;

    // Encoding 2'b11 is reserved and behaves as JOIN_ALL.
    function automatic join_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'b01:   return JOIN_ANY;
            2'b10:   return JOIN_NONE;
            default: return JOIN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/fj_prio_enc.sv
// Lowest-index priority encoder used to pick the first completing worker slot.
module fj_prio_enc #(
    parameter int unsigned N_PROC = 4
) (
    input  logic [N_PROC-1:0]         i_req,
    output logic [$clog2(N_PROC)-1:0] o_idx
);

    localparam int unsigned IDX_W = $clog2(N_PROC);

    always_comb begin
        o_idx = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches a group of worker slots and releases the parent per join policy.
// Optional watchdog enabled with `define FORK_JOIN_WATCHDOG_EN (adds the timeout output).
module fork_join_ctrl
    import fork_join_pkg::*;
#(
    parameter int unsigned N_PROC         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fork_req,
    input  logic [N_PROC-1:0]         fork_mask,
    input  logic [1:0]                join_mode,
    input  logic [N_PROC-1:0]         proc_done,
    output logic                      fork_ready,
    output logic [N_PROC-1:0]         proc_start,
    output logic [N_PROC-1:0]         pending,
    output logic                      resume,
`ifdef FORK_JOIN_WATCHDOG_EN
    output logic                      timeout,
`endif
    output logic [$clog2(N_PROC)-1:0] first_id
);

    localparam int unsigned ID_W = $clog2(N_PROC);

    state_e             r_state,    w_state_next;
    join_mode_e         r_mode,     w_mode_next;
    logic  [N_PROC-1:0] r_pending,  w_pending_next;
    logic               r_resume,   w_resume_next;
    logic  [ID_W-1:0]   r_first_id, w_first_id_next;
    logic  [N_PROC-1:0] w_done_hit;
    logic  [N_PROC-1:0] w_pend_clr;
    logic  [ID_W-1:0]   w_prio_idx;

`ifdef FORK_JOIN_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wd_cnt,  w_wd_cnt_next;
    logic             r_timeout, w_timeout_next;
`endif

    // Completions only count for slots that are still outstanding.
    assign w_done_hit = r_pending & proc_done;
    assign w_pend_clr = r_pending & ~proc_done;

    fj_prio_enc #(
        .N_PROC (N_PROC)
    ) u_prio_enc (
        .i_req (w_done_hit),
        .o_idx (w_prio_idx)
    );

    always_comb begin
        w_state_next    = r_state;
        w_mode_next     = r_mode;
        w_pending_next  = r_pending;
        w_resume_next   = 1'b0;
        w_first_id_next = r_first_id;
        case (r_state)
            IDLE: begin
                if (fork_req) begin
                    w_mode_next     = decode_mode(join_mode);
                    w_first_id_next = '0;
                    w_pending_next  = fork_mask;
                    // An empty group has nothing to wait for: release immediately.
                    if (fork_mask == '0) begin
                        w_resume_next = 1'b1;
                    end else begin
                        w_state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (r_mode == JOIN_NONE) begin
                    w_resume_next = 1'b1;
                    w_state_next  = DRAIN;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_pending_next = w_pend_clr;
                if (r_mode == JOIN_ANY) begin
                    if (|w_done_hit) begin
                        w_first_id_next = w_prio_idx;
                        w_resume_next   = 1'b1;
                        w_state_next    = (w_pend_clr == '0) ? IDLE : DRAIN;
                    end
                end else if (w_pend_clr == '0) begin
                    w_resume_next = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            DRAIN: begin
                w_pending_next = w_pend_clr;
                if (w_pend_clr == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

`ifdef FORK_JOIN_WATCHDOG_EN
        w_timeout_next = 1'b0;
        w_wd_cnt_next  = r_wd_cnt;
        if (r_state == LAUNCH) begin
            w_wd_cnt_next = '0;
        end else if (r_state == WAIT || r_state == DRAIN) begin
            w_wd_cnt_next = r_wd_cnt + 1'b1;
            if (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                // A DRAIN group already released the parent, so only WAIT owes a resume.
                w_timeout_next = 1'b1;
                w_pending_next = '0;
                w_state_next   = IDLE;
                w_resume_next  = (r_state == WAIT);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= JOIN_ALL;
            r_pending  <= '0;
            r_resume   <= 1'b0;
            r_first_id <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mode     <= w_mode_next;
            r_pending  <= w_pending_next;
            r_resume   <= w_resume_next;
            r_first_id <= w_first_id_next;
        end
    end

`ifdef FORK_JOIN_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd_cnt  <= w_wd_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout = r_timeout;
`endif

    assign fork_ready = (r_state == IDLE);
    assign proc_start = (r_state == LAUNCH) ? r_pending : '0;
    assign pending    = r_pending;
    assign resume     = r_resume;
    assign first_id   = r_first_id;

endmodule
